hazard_unit: RTL and testbench

- Pipeline hazard resolver for the 5-stage MIPS core.
- Consumes the per-stage control bits the controller pipelines (regwrite*, memtoreg*, branch/bne, multiply/divide start).
- Returns stall, flush and forwarding selects to the controller and datapath, closing the loop on flushE.
- Adds a sequential multiply/divide busy tracker so HI/LO readers and back-to-back mul/div ops stall until the iterative unit completes.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/md_busy_tracker.sv | 46 ++++
 rtl/hazard_unit.sv | 113 +++++++++++
 tb/tb_hazard_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard resolver.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks occupancy of the iterative multiply/divide unit with a load/decrement counter.
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic mdstartE,
  input  logic mddivE,
  output logic mdbusy
);

  localparam int unsigned MaxCycles = max_u(MULT_CYCLES, DIV_CYCLES);
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;

  // A start while the counter is running is dropped; correct stalling never produces one.
  always_comb begin
    w_cnt_d = r_cnt;
    if (mdstartE && (r_cnt == '0)) begin
      w_cnt_d = mddivE ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
    end else if (r_cnt != '0) begin
      w_cnt_d = r_cnt - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign mdbusy = (r_cnt != '0);

`ifndef SYNTHESIS
  a_no_start_while_busy: assert property (@(posedge clk) disable iff (reset)
    !(mdstartE && mdbusy));
`endif

endmodule

// File: rtl/hazard_unit.sv
// Stall, flush and forwarding control for the 5-stage MIPS pipeline.
// Optional stall performance counter enabled by HAZARD_STALL_PERF_EN.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        rsD,
  input  logic [4:0]        rtD,
  input  logic [4:0]        rsE,
  input  logic [4:0]        rtE,
  input  logic [4:0]        writeregE,
  input  logic [4:0]        writeregM,
  input  logic [4:0]        writeregW,
  input  logic              regwriteE,
  input  logic              regwriteM,
  input  logic              regwriteW,
  input  logic              memtoregE,
  input  logic              memtoregM,
  input  logic              branchD,
  input  logic              bneD,
  input  logic              mdstartD,
  input  logic              mdstartE,
  input  logic              mddivE,
  input  logic              mfhiloD,
  output logic              stallF,
  output logic              stallD,
  output logic              flushE,
  output logic              forwardAD,
  output logic              forwardBD,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              mdbusy,
  output logic [PERF_W-1:0] stall_count
);

  fwd_sel_t w_fwd_ae;
  fwd_sel_t w_fwd_be;
  logic     w_lwstall;
  logic     w_branchstall;
  logic     w_mdstall;
  logic     w_stall;
  logic     w_mdbusy;

  // M-stage result is newer than W, so it takes priority.
  always_comb begin
    w_fwd_ae = FWD_RF;
    if ((rsE != REG_ZERO) && regwriteM && (rsE == writeregM)) begin
      w_fwd_ae = FWD_MEM;
    end else if ((rsE != REG_ZERO) && regwriteW && (rsE == writeregW)) begin
      w_fwd_ae = FWD_WB;
    end
  end

  always_comb begin
    w_fwd_be = FWD_RF;
    if ((rtE != REG_ZERO) && regwriteM && (rtE == writeregM)) begin
      w_fwd_be = FWD_MEM;
    end else if ((rtE != REG_ZERO) && regwriteW && (rtE == writeregW)) begin
      w_fwd_be = FWD_WB;
    end
  end

  assign forwardAE = w_fwd_ae;
  assign forwardBE = w_fwd_be;
  assign forwardAD = (rsD != REG_ZERO) && regwriteM && (rsD == writeregM);
  assign forwardBD = (rtD != REG_ZERO) && regwriteM && (rtD == writeregM);

  md_busy_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy (
    .clk      (clk),
    .reset    (reset),
    .mdstartE (mdstartE),
    .mddivE   (mddivE),
    .mdbusy   (w_mdbusy)
  );

  assign w_lwstall     = memtoregE && ((rtE == rsD) || (rtE == rtD));
  assign w_branchstall = (branchD || bneD) &&
                         ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                          (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));
  // The mdstartE term covers the start cycle, before the counter has loaded.
  assign w_mdstall     = (mfhiloD || mdstartD) && (w_mdbusy || mdstartE);
  assign w_stall       = w_lwstall || w_branchstall || w_mdstall;

  assign stallF = w_stall;
  assign stallD = w_stall;
  assign flushE = w_stall;
  assign mdbusy = w_mdbusy;

`ifdef HAZARD_STALL_PERF_EN
  logic [PERF_W-1:0] r_stall_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != {PERF_W{1'b1}})) begin
      r_stall_count <= r_stall_count + PERF_W'(1);
    end
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed cases plus random traffic against a reference model.
module tb_hazard_unit;

  localparam int unsigned MULT_N = 4;
  localparam int unsigned DIV_N  = 32;
  localparam int unsigned PERF_W = 4;
  localparam longint      CNT_MAX = (longint'(1) << PERF_W) - 1;

  typedef struct {
    logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
    logic rwE, rwM, rwW, mtrE, mtrM, brD, bneD, mdsD, mdsE, mddivE, mfhiloD;
  } stim_t;

  typedef struct {
    int     stall;
    int     fae, fbe, fad, fbd, busy;
    longint cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD, bneD;
  logic mdstartD, mdstartE, mddivE, mfhiloD;
  logic stallF, stallD, flushE, forwardAD, forwardBD, mdbusy;
  logic [1:0] forwardAE, forwardBE;
  logic [PERF_W-1:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q[$];

  // Reference model state: cycle index, last busy cycle, stall tally.
  int     cur      = 0;
  int     busy_end = -1;
  longint cnt      = 0;

  always #5 clk = ~clk;

  hazard_unit #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N),
    .PERF_W      (PERF_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rsD         (rsD),
    .rtD         (rtD),
    .rsE         (rsE),
    .rtE         (rtE),
    .writeregE   (writeregE),
    .writeregM   (writeregM),
    .writeregW   (writeregW),
    .regwriteE   (regwriteE),
    .regwriteM   (regwriteM),
    .regwriteW   (regwriteW),
    .memtoregE   (memtoregE),
    .memtoregM   (memtoregM),
    .branchD     (branchD),
    .bneD        (bneD),
    .mdstartD    (mdstartD),
    .mdstartE    (mdstartE),
    .mddivE      (mddivE),
    .mfhiloD     (mfhiloD),
    .stallF      (stallF),
    .stallD      (stallD),
    .flushE      (flushE),
    .forwardAD   (forwardAD),
    .forwardBD   (forwardBD),
    .forwardAE   (forwardAE),
    .forwardBE   (forwardBE),
    .mdbusy      (mdbusy),
    .stall_count (stall_count)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int fwd_e(input stim_t s, input logic [4:0] src);
    if (src != 0 && s.rwM && src == s.wM) return 2;
    if (src != 0 && s.rwW && src == s.wW) return 1;
    return 0;
  endfunction

  function automatic exp_t model(input stim_t s);
    exp_t e;
    bit busy, lw, br, md;
    busy   = (cur <= busy_end);
    lw     = s.mtrE && (s.rtE == s.rsD || s.rtE == s.rtD);
    br     = (s.brD || s.bneD) &&
             ((s.rwE && (s.wE == s.rsD || s.wE == s.rtD)) ||
              (s.mtrM && (s.wM == s.rsD || s.wM == s.rtD)));
    md     = (s.mfhiloD || s.mdsD) && (busy || s.mdsE);
    e.stall = (lw || br || md) ? 1 : 0;
    e.fae   = fwd_e(s, s.rsE);
    e.fbe   = fwd_e(s, s.rtE);
    e.fad   = (s.rsD != 0 && s.rwM && s.rsD == s.wM) ? 1 : 0;
    e.fbd   = (s.rtD != 0 && s.rwM && s.rtD == s.wM) ? 1 : 0;
    e.busy  = busy ? 1 : 0;
`ifdef HAZARD_STALL_PERF_EN
    e.cnt   = cnt;
`else
    e.cnt   = 0;
`endif
    return e;
  endfunction

  task automatic drive(input stim_t s);
    rsD = s.rsD; rtD = s.rtD; rsE = s.rsE; rtE = s.rtE;
    writeregE = s.wE; writeregM = s.wM; writeregW = s.wW;
    regwriteE = s.rwE; regwriteM = s.rwM; regwriteW = s.rwW;
    memtoregE = s.mtrE; memtoregM = s.mtrM; branchD = s.brD; bneD = s.bneD;
    mdstartD = s.mdsD; mdstartE = s.mdsE; mddivE = s.mddivE; mfhiloD = s.mfhiloD;
  endtask

  // Called at posedge+1; returns at the next posedge+1 with the model advanced.
  task automatic step(input stim_t s);
    exp_t e;
    drive(s);
    e = model(s);
    q.push_back(e);
    if (s.mdsE && cur > busy_end) busy_end = cur + (s.mddivE ? DIV_N : MULT_N);
    @(posedge clk); #1;
    if (e.stall != 0 && cnt < CNT_MAX) cnt++;
    cur++;
  endtask

  // Same as step, but pulses reset after the monitor has sampled this cycle.
  task automatic step_reset(input stim_t s);
    exp_t e;
    drive(s);
    e = model(s);
    q.push_back(e);
    #5 reset = 1'b1;
    #1;
    chk("async_mdbusy", longint'(mdbusy), 0);
    chk("async_stall", longint'(stallD), 0);
    chk("async_count", longint'(stall_count), 0);
    #1 reset = 1'b0;
    busy_end = -1;
    cnt      = 0;
    @(posedge clk); #1;
    cur++;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.rsD = 5'($urandom_range(0, 3)); s.rtD = 5'($urandom_range(0, 3));
    s.rsE = 5'($urandom_range(0, 3)); s.rtE = 5'($urandom_range(0, 3));
    s.wE  = 5'($urandom_range(0, 3)); s.wM  = 5'($urandom_range(0, 3));
    s.wW  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
    s.rwE = 1'($urandom); s.rwM = 1'($urandom); s.rwW = 1'($urandom);
    s.mtrE = ($urandom_range(0, 3) == 0); s.mtrM = ($urandom_range(0, 3) == 0);
    s.brD  = ($urandom_range(0, 3) == 0); s.bneD = ($urandom_range(0, 5) == 0);
    s.mdsD = ($urandom_range(0, 5) == 0); s.mfhiloD = ($urandom_range(0, 4) == 0);
    s.mdsE = (cur > busy_end) && ($urandom_range(0, 7) == 0);
    s.mddivE = ($urandom_range(0, 3) == 0);
    return s;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && q.size() > 0) begin
      e = q.pop_front();
      chk("stallF", longint'(stallF), e.stall);
      chk("stallD", longint'(stallD), e.stall);
      chk("flushE", longint'(flushE), e.stall);
      chk("forwardAE", longint'(forwardAE), e.fae);
      chk("forwardBE", longint'(forwardBE), e.fbe);
      chk("forwardAD", longint'(forwardAD), e.fad);
      chk("forwardBD", longint'(forwardBD), e.fbd);
      chk("mdbusy", longint'(mdbusy), e.busy);
      chk("stall_count", longint'(stall_count), e.cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t z, s;
    z = '{default: '0};
    reset = 1'b1;
    drive(z);
    #3;
    chk("rst_stall", longint'(stallD), 0);
    chk("rst_fwdAE", longint'(forwardAE), 0);
    chk("rst_mdbusy", longint'(mdbusy), 0);
    chk("rst_count", longint'(stall_count), 0);
    #4 reset = 1'b0;
    @(posedge clk); #1;

    // Forwarding priority: M over W, r0 never forwarded.
    s = z; s.rsE = 5; s.wM = 5; s.rwM = 1; s.wW = 5; s.rwW = 1;
    step(s);
    s.rwM = 0; step(s);
    s.rsE = 0; step(s);

    // Load-use stall for a single cycle.
    s = z; s.mtrE = 1; s.rtE = 8; s.rsD = 8;
    step(s);
    s.mtrE = 0; step(s);

    // Branch hazards: ALU result in E, load in M, then bypass from M.
    s = z; s.brD = 1; s.rsD = 3; s.rwE = 1; s.wE = 3;
    step(s);
    s = z; s.brD = 1; s.rsD = 3; s.mtrM = 1; s.rwM = 1; s.wM = 3;
    step(s);
    s.mtrM = 0; step(s);

    // Multiply start with mfhi waiting behind it.
    s = z; s.mdsE = 1; s.mfhiloD = 1;
    step(s);
    s.mdsE = 0;
    for (int i = 0; i < 6; i++) step(s);

    // Divide start, reset on the tenth cycle, then a fresh divide.
    s = z; s.mdsE = 1; s.mddivE = 1; s.mfhiloD = 1;
    step(s);
    s.mdsE = 0;
    for (int i = 0; i < 9; i++) step(s);
    step_reset(s);
    s.mdsE = 1; step(s);
    s.mdsE = 0;
    for (int i = 0; i < DIV_N + 2; i++) step(s);

    // Sustained stall drives the counter into saturation.
    s = z; s.mtrE = 1; s.rtE = 2; s.rsD = 2;
    for (int i = 0; i < 20; i++) step(s);

    for (int i = 0; i < 400; i++) step(rand_stim());

    step(z);
    step(z);
    chk("queue_drained", longint'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
